// File: rtl/cordic_atan_post_pkg.sv
// Shared constants and types for the CORDIC atan/magnitude output stage.
// Used by cordic_tag_delay and cordic_atan_post.
package cordic_atan_post_pkg;

  localparam int DATA_W    = 32;
  localparam int ANG_W     = 12;
  localparam int ANGLE_PI  = 2048;
  localparam int MAG_TERMS = 6;

  // Gain compensation: f * 0.607239 ~= sum over i of (+/-)(f >>> MAG_SHIFT[i]); MAG_NEG[i] marks subtracted terms
  localparam int MAG_SHIFT [MAG_TERMS] = '{1, 3, 6, 9, 12, 14};
  localparam logic [MAG_TERMS-1:0] MAG_NEG = 6'b011100;

  typedef struct packed {
    logic valid;
    logic qflag;
    logic zflag;
  } tag_t;

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-length shift register carrying per-sample tags alongside the CORDIC
// iteration pipeline; shifts every cycle, cleared by asynchronous reset.
module cordic_tag_delay
  import cordic_atan_post_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic rx_clk,
  input  logic rx_rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t sr [DEPTH];

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/cordic_atan_post.sv
// CORDIC vectoring output stage: quadrant/zero correction, optional gain
// compensation (macro CORDIC_MAG_COMP_EN) and a valid/ready holding register.
module cordic_atan_post
  import cordic_atan_post_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int CNT_W = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic signed [DATA_W-1:0] fin_x,
  input  logic signed [ANG_W-1:0]  fin_z,
  input  logic                     out_ready,
  input  logic                     sticky_clr,
  output logic                     out_valid,
  output logic signed [ANG_W-1:0]  out_angle,
  output logic signed [DATA_W-1:0] out_mag,
  output logic                     out_zero,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     drop_sticky
);

  // Adding pi modulo 2*pi only flips the MSB of the angle word.
  function automatic logic signed [ANG_W-1:0] fix_angle(input tag_t t,
                                                         input logic signed [ANG_W-1:0] z);
    logic signed [ANG_W-1:0] a;
    a = z;
    if (t.qflag) a = z ^ ANG_W'(ANGLE_PI);
    if (t.zflag) a = '0;
    return a;
  endfunction

  function automatic logic signed [DATA_W-1:0] fix_mag(input tag_t t,
                                                       input logic signed [DATA_W-1:0] m);
    return t.zflag ? '0 : m;
  endfunction

`ifdef CORDIC_MAG_COMP_EN
  function automatic logic signed [DATA_W-1:0] mag_comp(input logic signed [DATA_W-1:0] f);
    logic signed [DATA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAG_TERMS; i++) begin
      if (MAG_NEG[i]) acc = acc - (f >>> MAG_SHIFT[i]);
      else            acc = acc + (f >>> MAG_SHIFT[i]);
    end
    return acc;
  endfunction
`endif

  tag_t tag_in;
  tag_t tag_tap;

  assign tag_in = '{valid: in_valid,
                    qflag: in_x[DATA_W-1],
                    zflag: (in_x == '0) && (in_y == '0)};

  cordic_tag_delay #(.DEPTH(DEPTH)) u_tag_delay (
    .rx_clk  (rx_clk),
    .rx_rst_n(rx_rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_tap)
  );

  // ---- stage p0: tap aligned with fin_x/fin_z ----
  logic                     vld_p0;
  logic signed [ANG_W-1:0]  angle_p0;
  logic                     zero_p0;

  assign vld_p0   = tag_tap.valid;
  assign angle_p0 = fix_angle(tag_tap, fin_z);
  assign zero_p0  = tag_tap.zflag;

  logic                     ld_vld;
  logic signed [ANG_W-1:0]  ld_angle;
  logic signed [DATA_W-1:0] ld_mag;
  logic                     ld_zero;

`ifdef CORDIC_MAG_COMP_EN
  // ---- stage p1: gain compensation register ----
  logic                     vld_p1;
  logic signed [ANG_W-1:0]  angle_p1;
  logic signed [DATA_W-1:0] mag_p1;
  logic                     zero_p1;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) vld_p1 <= 1'b0;
    else           vld_p1 <= vld_p0;
  end

  always_ff @(posedge rx_clk) begin
    angle_p1 <= angle_p0;
    mag_p1   <= fix_mag(tag_tap, mag_comp(fin_x));
    zero_p1  <= zero_p0;
  end

  assign ld_vld   = vld_p1;
  assign ld_angle = angle_p1;
  assign ld_mag   = mag_p1;
  assign ld_zero  = zero_p1;
`else
  assign ld_vld   = vld_p0;
  assign ld_angle = angle_p0;
  assign ld_mag   = fix_mag(tag_tap, fin_x);
  assign ld_zero  = zero_p0;
`endif

  // ---- holding register: valid/ready output with drop detection ----
  logic accept;
  logic drop;

  assign accept = out_valid && out_ready;
  assign drop   = ld_vld && out_valid && !out_ready;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      out_valid   <= 1'b0;
      out_angle   <= '0;
      out_mag     <= '0;
      out_zero    <= 1'b0;
      out_cnt     <= '0;
      drop_sticky <= 1'b0;
    end else begin
      if (ld_vld) begin
        out_valid <= 1'b1;
        out_angle <= ld_angle;
        out_mag   <= ld_mag;
        out_zero  <= ld_zero;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) out_cnt <= out_cnt + CNT_W'(1);
      if (drop)            drop_sticky <= 1'b1;
      else if (sticky_clr) drop_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_atan_post.sv
// Self-checking bench for cordic_atan_post: directed vector table, reset,
// drop/sticky sequences, randomized traffic and counter wrap.
module tb_cordic_atan_post;

  localparam int DEPTH = 12;
  localparam int CNT_W = 16;
`ifdef CORDIC_MAG_COMP_EN
  localparam int LAT  = DEPTH + 2;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = DEPTH + 1;
  localparam bit COMP = 1'b0;
`endif

  logic              rx_clk = 1'b0;
  logic              rx_rst_n;
  logic              in_valid;
  logic [31:0]       in_x, in_y, fin_x;
  logic [11:0]       fin_z;
  logic              out_ready, sticky_clr;
  logic              out_valid;
  logic [11:0]       out_angle;
  logic [31:0]       out_mag;
  logic              out_zero;
  logic [CNT_W-1:0]  out_cnt;
  logic              drop_sticky;

  cordic_atan_post #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .rx_clk     (rx_clk),
    .rx_rst_n   (rx_rst_n),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .fin_x      (fin_x),
    .fin_z      (fin_z),
    .out_ready  (out_ready),
    .sticky_clr (sticky_clr),
    .out_valid  (out_valid),
    .out_angle  (out_angle),
    .out_mag    (out_mag),
    .out_zero   (out_zero),
    .out_cnt    (out_cnt),
    .drop_sticky(drop_sticky)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct { logic [11:0] angle; logic [31:0] mag; logic zero; } res_t;
  typedef struct { int due; res_t r; } pend_t;
  typedef struct { logic [31:0] fx; logic [11:0] fz; } fin_t;
  typedef struct {
    logic [31:0] x, y, fx; logic [11:0] fz;
    logic [11:0] ea; logic [31:0] em; logic ez;
  } vec_t;

  pend_t pend[$];
  fin_t  finq[$];
  bit    m_valid, m_drop;
  res_t  m_res;
  int    m_cnt;
  int    cyc, checks, errors;
  bit    chk_en;

  function automatic logic [31:0] comp_mag(input logic signed [31:0] f);
    return (f >>> 1) + (f >>> 3) - (f >>> 6) - (f >>> 9) - (f >>> 12) + (f >>> 14);
  endfunction

  function automatic res_t ref_res(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] fx, input logic [11:0] fz);
    res_t r;
    if (x == 0 && y == 0) begin
      r.angle = '0; r.mag = '0; r.zero = 1'b1;
    end else begin
      r.zero  = 1'b0;
      r.angle = ($signed(x) < 0) ? 12'((int'(fz) + 2048) % 4096) : fz;
      r.mag   = COMP ? comp_mag(fx) : fx;
    end
    return r;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] with_comp, input logic [31:0] without);
    return COMP ? with_comp : without;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference model at the edge, compare after it.
  task automatic cycle(input bit v, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] fx, input logic [11:0] fz,
                       input bit rdy, input bit clr);
    fin_t  f;
    pend_t p;
    bit    load, acc;
    in_valid = v; in_x = x; in_y = y; out_ready = rdy; sticky_clr = clr;
    finq.push_back('{fx, fz});
    f = finq.pop_front();
    fin_x = f.fx; fin_z = f.fz;
    if (v) pend.push_back('{cyc + LAT, ref_res(x, y, fx, fz)});
    @(posedge rx_clk);
    cyc++;
    load = (pend.size() > 0) && (pend[0].due == cyc);
    acc  = m_valid && rdy;
    if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (load && m_valid && !rdy) m_drop = 1'b1;
    else if (clr)                m_drop = 1'b0;
    if (load) begin
      p = pend.pop_front();
      m_res = p.r; m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    #1;
    if (chk_en) begin
      check("valid", out_valid, m_valid);
      check("cnt", out_cnt, m_cnt);
      check("drop", drop_sticky, m_drop);
      if (m_valid) begin
        check("angle", out_angle, m_res.angle);
        check("mag", out_mag, m_res.mag);
        check("zero", out_zero, m_res.zero);
      end
    end
  endtask

  task automatic idle(input bit rdy, input bit clr);
    cycle(1'b0, $urandom, $urandom, $urandom, 12'($urandom), rdy, clr);
  endtask

  task automatic model_clear();
    pend.delete();
    m_valid = 1'b0; m_drop = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_angle"}, out_angle, 0);
    check({tag, "_mag"}, out_mag, 0);
    check({tag, "_zero"}, out_zero, 0);
    check({tag, "_cnt"}, out_cnt, 0);
    check({tag, "_drop"}, drop_sticky, 0);
  endtask

  vec_t  vt [7];
  res_t  last;
  logic [31:0] rx, ry;

  initial begin
    checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
    rx_rst_n = 1'b0; in_valid = 0; in_x = 0; in_y = 0; fin_x = 0; fin_z = 0;
    out_ready = 0; sticky_clr = 0;
    for (int i = 0; i < DEPTH; i++) finq.push_back('{32'd0, 12'd0});
    model_clear();

    vt[0] = '{32'd100, 32'd100, 32'd1000, 12'd512, 12'd512, pick(32'd609, 32'd1000), 1'b0};
    vt[1] = '{-32'sd100, 32'd0, 32'd100, 12'd0, 12'h800, pick(32'd61, 32'd100), 1'b0};
    vt[2] = '{-32'sd100, -32'sd1, 32'd164672, 12'hFFD, 12'h7FD, pick(32'd99996, 32'd164672), 1'b0};
    vt[3] = '{32'd0, 32'd0, 32'd55, 12'd17, 12'd0, 32'd0, 1'b1};
    vt[4] = '{32'd5, -32'sd7, -32'sd64, 12'hED4, 12'hED4, pick(-32'sd38, -32'sd64), 1'b0};
    vt[5] = '{32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 12'h7FF, 12'hFFF,
              pick(32'd1304035328, 32'h7FFF_FFFF), 1'b0};
    vt[6] = '{32'd0, 32'd1, 32'd7, 12'd1024, 12'd1024, pick(32'd3, 32'd7), 1'b0};

    repeat (3) @(posedge rx_clk);
    #1;
    check_all_zero("reset");
    rx_rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed vectors with exact latency
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vt[i].x, vt[i].y, vt[i].fx, vt[i].fz, 1'b1, 1'b0);
      repeat (LAT - 2) idle(1'b1, 1'b0);
      check("lat_early", out_valid, 0);
      idle(1'b1, 1'b0);
      check("lat_valid", out_valid, 1);
      check("vec_angle", out_angle, vt[i].ea);
      check("vec_mag", out_mag, vt[i].em);
      check("vec_zero", out_zero, vt[i].ez);
      repeat (2) idle(1'b1, 1'b0);
    end

    // Reset with samples in flight
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'd10 + i, 32'd3, 32'd77, 12'd5, 1'b1, 1'b0);
    repeat (2) idle(1'b1, 1'b0);
    #2 rx_rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge rx_clk); @(posedge rx_clk); #1;
    rx_rst_n = 1'b1;
    model_clear();
    repeat (LAT + 5) idle(1'b1, 1'b0);
    check("rst_no_emit", out_valid, 0);
    cycle(1'b1, 32'd9, 32'd9, 32'd321, 12'd100, 1'b1, 1'b0);
    repeat (LAT + 2) idle(1'b1, 1'b0);

    // Back-to-back samples with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      rx = $urandom; ry = $urandom;
      cycle(1'b1, rx, ry, 32'd1000 + i, 12'(40 * i), (i < 3), 1'b0);
      last = ref_res(rx, ry, 32'd1000 + i, 12'(40 * i));
    end
    repeat (LAT) idle(1'b0, 1'b0);
    check("stall_drop", drop_sticky, 1);
    check("stall_valid", out_valid, 1);
    check("stall_keep_angle", out_angle, last.angle);
    check("stall_keep_mag", out_mag, last.mag);
    idle(1'b0, 1'b1);
    check("clr_alone", drop_sticky, 0);
    cycle(1'b1, 32'd1, 32'd2, 32'd3, 12'd4, 1'b0, 1'b0);
    repeat (LAT - 2) idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check("clr_vs_set", drop_sticky, 1);
    idle(1'b1, 1'b1);
    check("clr_after", drop_sticky, 0);
    repeat (LAT + 2) idle(1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rx = (sel < 2) ? 32'd0 : $urandom;
      ry = (sel == 0) ? 32'd0 : $urandom;
      cycle($urandom_range(0, 9) < 7, rx, ry, $urandom, 12'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (LAT + 2) idle(1'b1, 1'b1);

    // Accepted-result counter wrap
    #2 rx_rst_n = 1'b0;
    @(posedge rx_clk); #1;
    rx_rst_n = 1'b1;
    model_clear();
    chk_en = 1'b0;
    for (int i = 0; i < (1 << CNT_W) - 1; i++)
      cycle(1'b1, 32'd50, 32'd1, 32'd2, 12'd3, 1'b1, 1'b0);
    repeat (LAT + 2) idle(1'b1, 1'b0);
    check("cnt_full", out_cnt, (1 << CNT_W) - 1);
    check("cnt_no_drop", drop_sticky, 0);
    chk_en = 1'b1;
    cycle(1'b1, 32'd50, 32'd1, 32'd2, 12'd3, 1'b1, 1'b0);
    repeat (LAT + 1) idle(1'b1, 1'b0);
    check("cnt_wrap", out_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_atan_post.md
Name: cordic_atan_post

Overview:
- Output stage of the CORDIC vectoring (atan/magnitude) pipeline. Sits directly after the last 32-bit/12-bit iteration stage.
- Tracks sample validity and pre-rotation quadrant through a delay line matched to the pipeline depth. Applies the ±pi quadrant correction and optional gain compensation.
- Presents registered angle/magnitude results to the consumer through a valid/ready holding register with sticky drop detection.

Parameters:
- DEPTH, 12, number of iteration stages between pipeline entry and fin_x/fin_z; delay-line length in cycles (1..32)
- CNT_W, 16, width of accepted-result counter

Ports:
- rx_clk  input  1  clock
- rx_rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  sample entering stage 0 this cycle
- in_x  input  32  raw signed x at pipeline entry, before pre-rotation
- in_y  input  32  raw signed y at pipeline entry
- fin_x  input  32  signed x from final iteration stage (gain-scaled magnitude)
- fin_z  input  12  signed angle from final iteration stage
- out_ready  input  1  consumer accepts out_* this cycle
- sticky_clr  input  1  clears drop_sticky
- out_valid  output  1  result held
- out_angle  output  12  corrected angle, two's complement, LSB = pi/2048, range [-2048, 2047]
- out_mag  output  32  magnitude (compensated if feature on)
- out_zero  output  1  sample had in_x = in_y = 0
- out_cnt  output  CNT_W  count of accepted results, wraps
- drop_sticky  output  1  a result was overwritten before acceptance

Behaviour:
- Reset: all outputs 0; delay lines cleared; pending entries are discarded, never emitted.
- At entry, per cycle, shift in the triple {in_valid, qflag = in_x[31], zflag = (in_x == 0 && in_y == 0)} into a DEPTH-long shift register. It shifts every cycle; there is no stall.
- The tap at DEPTH is aligned with fin_x/fin_z of the same sample.
- Angle correction: if qflag, angle = fin_z + 2048 mod 4096 (MSB invert, maps ±pi symmetrically). Otherwise angle = fin_z. If zflag, angle = 0 and mag = 0.
- Latency: result registered into the holding register at cycle t+DEPTH+1 for in_valid at cycle t (t+DEPTH+2 with feature).
- Holding register:
  - Loads when the tap is valid.
  - out_valid is set on load and cleared on an out_ready handshake with no simultaneous load.
  - Load while out_valid=1 and out_ready=0 overwrites the register and sets drop_sticky.
  - Load with out_ready=1 in the same cycle counts as accepted, not a drop.
- out_cnt increments on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- drop_sticky: set has priority over sticky_clr in the same cycle.
- Back-to-back valid samples every cycle are supported: throughput is 1/cycle and out_ready must be held high to avoid drops.

Optional Feature:
- Macro: CORDIC_MAG_COMP_EN.
- Defined: mag = (f>>>1) + (f>>>3) − (f>>>6) − (f>>>9) − (f>>>12) + (f>>>14), with f = fin_x.
  - Each term is an arithmetic shift with truncation; the sum is 32-bit.
  - Gain ≈ 0.607239.
  - Adds one register stage; the flags and angle are delayed equally.
- Undefined: mag = fin_x unchanged, with the base latency.

Decomposition:
- Shared package holds:
  - Angle width 12 and data width 32 constants.
  - ANGLE_PI = 2048.
  - The gain-compensation shift list.
  - The delay-line tag struct type {valid, qflag, zflag}.
- One sub-module is natural: cordic_tag_delay, a parameterised DEPTH shift register with asynchronous active-low reset.

Test Plan:
- Reset mid-stream: 5 valid samples in flight, assert rx_rst_n=0 → outputs 0 immediately; no out_valid after release until a new in_valid plus latency.
- in_x=100, in_y=100, fin_z=512 at tap → out_angle=512, qflag=0, out_valid exactly DEPTH+1 cycles after in_valid.
- in_x=−100, in_y=0, fin_z=0 → out_angle=0x800 (−2048); in_x=−100, in_y=−1, fin_z=−3 (0xFFD) → out_angle=0x7FD.
- in_x=in_y=0, fin_x=55, fin_z=17 → out_angle=0, out_mag=0, out_zero=1.
- CORDIC_MAG_COMP_EN defined, fin_x=164672 → out_mag=99996 at DEPTH+2; undefined → out_mag=164672 at DEPTH+1.
- Valid every cycle, out_ready low for 2 cycles → drop_sticky=1, last result retained; sticky_clr together with a new drop → stays 1; 65536 accepted results → out_cnt wraps to 0.
